mix_optim_ctrl: RTL and testbench

MIX_OPTIM_CTRL -- requirements
Module: mix_optim_ctrl

---
 rtl/mix_optim_ctrl_if.sv | 31 +++
 rtl/mix_optim_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mix_optim_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mix_optim_ctrl_if.sv
// Handshake and RAM-strobe bundle between the optimizer controller and its surroundings.
interface mix_optim_ctrl_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  update;
  logic                  zero_grad;
  logic                  bwd_busy;
  logic                  valid_update;
  logic                  valid_zero_grad;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  ren;
  logic                  sel_b;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wen_param;
  logic                  wen_grad;

  // Requester side: issues jobs, observes completion and RAM strobes.
  modport master (
    output update, zero_grad, bwd_busy,
    input  valid_update, valid_zero_grad, busy, raddr, ren, sel_b,
           waddr, wen_param, wen_grad
  );

  // Controller side.
  modport slave (
    input  update, zero_grad, bwd_busy,
    output valid_update, valid_zero_grad, busy, raddr, ren, sel_b,
           waddr, wen_param, wen_grad
  );
endinterface

// File: rtl/mix_optim_ctrl.sv
// Optimizer / gradient-clear sequencer for the mix layers. Walks the weight
// then bias RAMs, either clearing gradients or streaming reads into a LAT-deep
// optimizer datapath whose results are written back LAT cycles later.
module mix_optim_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int W_WORDS    = 384,
  parameter int B_WORDS    = 72,
  parameter int LAT        = 3
) (
  input logic           clk,
  input logic           rst_n,
  mix_optim_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ZERO_W  = 3'd1,
    ZERO_B  = 3'd2,
    UPD_W   = 3'd3,
    UPD_B   = 3'd4,
    DRAIN_W = 3'd5,
    DRAIN_B = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] W_LAST = ADDR_WIDTH'(W_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] B_LAST = ADDR_WIDTH'(B_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] D_LAST = ADDR_WIDTH'(LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic                  upd_pend, upd_pend_next;
  logic                  zg_pend, zg_pend_next;
  logic                  job_upd, job_upd_next;

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_sel;

  logic                  pipe_v    [LAT];
  logic [ADDR_WIDTH-1:0] pipe_addr [LAT];
  logic                  pipe_sel  [LAT];

  // State, counter, pending-request and job-type registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      upd_pend <= 1'b0;
      zg_pend  <= 1'b0;
      job_upd  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      upd_pend <= upd_pend_next;
      zg_pend  <= zg_pend_next;
      job_upd  <= job_upd_next;
    end
  end

  // Next-state logic; a request in the same cycle as the IDLE decision counts as pending.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt + ONE;
    upd_pend_next = upd_pend | bus.update;
    zg_pend_next  = zg_pend | bus.zero_grad;
    job_upd_next  = job_upd;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!bus.bwd_busy) begin
          if (upd_pend || bus.update) begin
            state_next    = UPD_W;
            upd_pend_next = 1'b0;
            job_upd_next  = 1'b1;
          end else if (zg_pend || bus.zero_grad) begin
            state_next   = ZERO_W;
            zg_pend_next = 1'b0;
            job_upd_next = 1'b0;
          end
        end
      end
      ZERO_W: begin
        if (cnt == W_LAST) begin
          state_next = ZERO_B;
          cnt_next   = '0;
        end
      end
      ZERO_B: begin
        if (cnt == B_LAST) begin
          state_next = DONE;
          cnt_next   = '0;
        end
      end
      UPD_W: begin
        if (cnt == W_LAST) begin
          state_next = DRAIN_W;
          cnt_next   = '0;
        end
      end
      DRAIN_W: begin
        if (cnt == D_LAST) begin
          state_next = UPD_B;
          cnt_next   = '0;
        end
      end
      UPD_B: begin
        if (cnt == B_LAST) begin
          state_next = DRAIN_B;
          cnt_next   = '0;
        end
      end
      DRAIN_B: begin
        if (cnt == D_LAST) begin
          state_next = DONE;
          cnt_next   = '0;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Read-side strobes come straight from the phase and counter.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    rd_sel  = 1'b0;
    if (state == UPD_W || state == UPD_B) begin
      rd_en   = 1'b1;
      rd_addr = cnt;
      rd_sel  = (state == UPD_B);
    end
  end

  // Write-side delay line matching the optimizer datapath latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_addr[i] <= '0;
        pipe_sel[i]  <= 1'b0;
      end
    end else begin
      pipe_v[0]    <= rd_en;
      pipe_addr[0] <= rd_addr;
      pipe_sel[0]  <= rd_sel;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_sel[i]  <= pipe_sel[i-1];
      end
    end
  end

  // Output decode; sel_b tracks the write side while draining.
  always_comb begin
    bus.busy            = 1'b0;
    bus.ren             = rd_en;
    bus.raddr           = rd_addr;
    bus.sel_b           = 1'b0;
    bus.wen_grad        = 1'b0;
    bus.wen_param       = pipe_v[LAT-1];
    bus.waddr           = pipe_v[LAT-1] ? pipe_addr[LAT-1] : '0;
    bus.valid_update    = 1'b0;
    bus.valid_zero_grad = 1'b0;
    case (state)
      ZERO_W: begin
        bus.busy     = 1'b1;
        bus.wen_grad = 1'b1;
        bus.waddr    = cnt;
      end
      ZERO_B: begin
        bus.busy     = 1'b1;
        bus.wen_grad = 1'b1;
        bus.waddr    = cnt;
        bus.sel_b    = 1'b1;
      end
      UPD_W: begin
        bus.busy = 1'b1;
      end
      UPD_B: begin
        bus.busy  = 1'b1;
        bus.sel_b = 1'b1;
      end
      DRAIN_W, DRAIN_B: begin
        bus.busy  = 1'b1;
        bus.sel_b = pipe_sel[LAT-1];
      end
      DONE: begin
        bus.valid_update    = job_upd;
        bus.valid_zero_grad = !job_upd;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mix_optim_ctrl.sv
// Directed scoreboard bench for mix_optim_ctrl with W_WORDS=4, B_WORDS=2, LAT=2.
module tb_mix_optim_ctrl;
  localparam int AW = 9;
  localparam int W  = 4;
  localparam int B  = 2;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst_n;

  mix_optim_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  mix_optim_ctrl #(
    .ADDR_WIDTH(AW),
    .W_WORDS(W),
    .B_WORDS(B),
    .LAT(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int rd_q[$];
  int wr_q[$];
  int vd_q[$];

  // Cycle counter used to timestamp every strobe.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int enc(int c, int kind, int sel, int addr);
    return (c << 16) | (kind << 13) | (sel << 12) | addr;
  endfunction

  task automatic check_output(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(string tag);
    int obs;
    obs = {bus.busy, bus.ren, bus.wen_param, bus.wen_grad, bus.valid_update,
           bus.valid_zero_grad, bus.sel_b, bus.raddr, bus.waddr};
    check_output(tag, obs, 0);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(bit u, bit z);
    bus.update    = u;
    bus.zero_grad = z;
    step(1);
    bus.update    = 1'b0;
    bus.zero_grad = 1'b0;
  endtask

  task automatic push_update(int s);
    int bs;
    for (int i = 0; i < W; i++) begin
      rd_q.push_back(enc(s + i, 0, 0, i));
      wr_q.push_back(enc(s + i + L, 1, 0, i));
    end
    bs = s + W + L;
    for (int j = 0; j < B; j++) begin
      rd_q.push_back(enc(bs + j, 0, 1, j));
      wr_q.push_back(enc(bs + j + L, 1, 1, j));
    end
    vd_q.push_back(enc(bs + B + L, 1, 0, 0));
  endtask

  task automatic push_zero(int s);
    for (int i = 0; i < W; i++) wr_q.push_back(enc(s + i, 2, 0, i));
    for (int j = 0; j < B; j++) wr_q.push_back(enc(s + W + j, 2, 1, j));
    vd_q.push_back(enc(s + W + B, 2, 0, 0));
  endtask

  // Monitor: every strobe seen mid-cycle must match the head of its queue.
  always @(negedge clk) begin
    if (bus.ren) begin
      check_output("rd_expected", int'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0)
        check_output("rd", enc(cyc, 0, int'(bus.sel_b), int'(bus.raddr)), rd_q.pop_front());
    end
    if (bus.wen_param || bus.wen_grad) begin
      check_output("wen_exclusive", int'(bus.wen_param && bus.wen_grad), 0);
      check_output("wr_expected", int'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0)
        check_output("wr", enc(cyc, bus.wen_param ? 1 : 2, int'(bus.sel_b), int'(bus.waddr)),
                     wr_q.pop_front());
    end
    if (bus.valid_update || bus.valid_zero_grad) begin
      check_output("valid_exclusive", int'(bus.valid_update && bus.valid_zero_grad), 0);
      check_output("vd_expected", int'(vd_q.size() > 0), 1);
      if (vd_q.size() > 0)
        check_output("valid", enc(cyc, bus.valid_update ? 1 : 2, 0, 0), vd_q.pop_front());
    end
  end

  // Directed sequence of scenarios.
  initial begin
    int c;
    rst_n         = 1'b0;
    bus.update    = 1'b0;
    bus.zero_grad = 1'b0;
    bus.bwd_busy  = 1'b0;
    #2;
    check_quiet("reset_outputs");
    step(2);
    rst_n = 1'b1;
    step(2);
    check_quiet("idle_after_reset");

    $display("[TB] zero_grad job");
    c = cyc;
    push_zero(c + 1);
    apply_stimulus(1'b0, 1'b1);
    check_output("zg_busy_start", int'(bus.busy), 1);
    step(8);
    check_quiet("zg_idle_end");

    $display("[TB] update job");
    c = cyc;
    push_update(c + 1);
    apply_stimulus(1'b1, 1'b0);
    check_output("upd_busy_start", int'(bus.busy), 1);
    step(12);
    check_quiet("upd_idle_end");

    $display("[TB] update and zero_grad together");
    c = cyc;
    push_update(c + 1);
    push_zero(c + 13);
    apply_stimulus(1'b1, 1'b1);
    step(20);
    check_quiet("both_idle_end");

    $display("[TB] zero_grad held off by bwd_busy");
    c = cyc;
    bus.bwd_busy = 1'b1;
    push_zero(c + 11);
    apply_stimulus(1'b0, 1'b1);
    step(8);
    check_output("bwd_hold_busy", int'(bus.busy), 0);
    step(1);
    bus.bwd_busy = 1'b0;
    step(10);
    check_quiet("bwd_idle_end");

    $display("[TB] repeated update requests during a job");
    c = cyc;
    push_update(c + 1);
    push_update(c + 13);
    apply_stimulus(1'b1, 1'b0);
    step(2);
    apply_stimulus(1'b1, 1'b0);
    step(1);
    apply_stimulus(1'b1, 1'b0);
    step(25);
    check_quiet("reupd_idle_end");

    $display("[TB] reset during weight update");
    c = cyc;
    rd_q.push_back(enc(c + 1, 0, 0, 0));
    rd_q.push_back(enc(c + 2, 0, 0, 1));
    apply_stimulus(1'b1, 1'b0);
    step(2);
    check_output("pre_reset_read", {bus.ren, bus.raddr}, {1'b1, 9'd2});
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset_outputs");
    step(2);
    rst_n = 1'b1;
    step(15);
    check_quiet("post_reset_idle");

    check_output("rd_q_empty", rd_q.size(), 0);
    check_output("wr_q_empty", wr_q.size(), 0);
    check_output("vd_q_empty", vd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
